// File: rtl/reorder_buffer_pkg.sv
// Shared reorder-buffer definitions: default geometry and the per-entry record.
package rob_pkg;

  localparam int DEPTH = 64;
  localparam int TAG_W = 6;

  typedef struct packed {
    logic        valid;
    logic        done;
    logic [31:0] PC;
    logic [4:0]  archReg;
    logic [5:0]  destReg_p;
    logic [5:0]  oldDestReg_p;
    logic        is_store;
    logic [31:0] data;
  } rob_entry_t;

endpackage

// File: rtl/reorder_buffer_src_lookup.sv
// Operand lookup for one issue-queue source: stored result first, then
// same-cycle writeback bypass with port 0 taking priority.
module rob_src_lookup
#(
  parameter int DEPTH = 64,
  parameter int TAG_W = 6
)
(
  input  logic [TAG_W-1:0] rob_num,
  input  logic [DEPTH-1:0] valid_vec,
  input  logic [DEPTH-1:0] done_vec,
  input  logic [31:0]      data_arr [DEPTH],
  input  logic             wb_valid0,
  input  logic [TAG_W-1:0] wb_robNum0,
  input  logic [31:0]      wb_data0,
  input  logic             wb_valid1,
  input  logic [TAG_W-1:0] wb_robNum1,
  input  logic [31:0]      wb_data1,
  input  logic             wb_valid2,
  input  logic [TAG_W-1:0] wb_robNum2,
  input  logic [31:0]      wb_data2,
  output logic             ready,
  output logic [31:0]      data
);

  // Priority select: completed entry, then ALU0, ALU1, ALU2 bypass.
  always_comb begin
    ready = 1'b0;
    data  = 32'd0;
    if (valid_vec[rob_num] && done_vec[rob_num]) begin
      ready = 1'b1;
      data  = data_arr[rob_num];
    end else if (wb_valid0 && (wb_robNum0 == rob_num)) begin
      ready = 1'b1;
      data  = wb_data0;
    end else if (wb_valid1 && (wb_robNum1 == rob_num)) begin
      ready = 1'b1;
      data  = wb_data1;
    end else if (wb_valid2 && (wb_robNum2 == rob_num)) begin
      ready = 1'b1;
      data  = wb_data2;
    end else begin
      ready = 1'b0;
      data  = 32'd0;
    end
  end

endmodule

// File: rtl/reorder_buffer.sv
// In-order-retire reorder buffer with three writeback ports and two operand lookups.
// Optional flush input is built when ROB_FLUSH_EN is defined.
module reorder_buffer
#(
  parameter int DEPTH = rob_pkg::DEPTH,
  parameter int TAG_W = rob_pkg::TAG_W
)
(
  input  logic             clk,
  input  logic             rst,
`ifdef ROB_FLUSH_EN
  input  logic             flush,
`endif
  input  logic             alloc_valid,
  input  logic [31:0]      alloc_PC,
  input  logic [4:0]       alloc_archReg,
  input  logic [5:0]       alloc_destReg_p,
  input  logic [5:0]       alloc_oldDestReg_p,
  input  logic             alloc_is_store,
  output logic             alloc_ready,
  output logic [TAG_W-1:0] alloc_robNum,
  input  logic             wb_valid0,
  input  logic [TAG_W-1:0] wb_robNum0,
  input  logic [31:0]      wb_data0,
  input  logic             wb_valid1,
  input  logic [TAG_W-1:0] wb_robNum1,
  input  logic [31:0]      wb_data1,
  input  logic             wb_valid2,
  input  logic [TAG_W-1:0] wb_robNum2,
  input  logic [31:0]      wb_data2,
  input  logic [TAG_W-1:0] src1_robNum,
  input  logic [TAG_W-1:0] src2_robNum,
  output logic             src1_ready,
  output logic             src2_ready,
  output logic [31:0]      src1_data,
  output logic [31:0]      src2_data,
  output logic             retire_valid,
  output logic [4:0]       retire_archReg,
  output logic [5:0]       retire_destReg_p,
  output logic [5:0]       retire_oldDestReg_p,
  output logic [31:0]      retire_data,
  output logic             retire_is_store,
  output logic [TAG_W:0]   count
);

  import rob_pkg::*;

  rob_entry_t       rob_r [DEPTH];
  logic [TAG_W-1:0] head_r;
  logic [TAG_W-1:0] tail_r;
  logic [TAG_W:0]   count_r;
  logic             flush_s;
  logic             alloc_fire_s;
  logic             retire_fire_s;
  logic             head_ready_s;
  logic [DEPTH-1:0] valid_s;
  logic [DEPTH-1:0] done_s;
  logic [31:0]      data_s [DEPTH];

`ifdef ROB_FLUSH_EN
  assign flush_s = flush;
`else
  assign flush_s = 1'b0;
`endif

  // Full is judged on the registered count only; a retire this cycle does not free a slot yet.
  assign alloc_ready   = (count_r < (TAG_W+1)'(DEPTH));
  assign alloc_robNum  = tail_r;
  assign alloc_fire_s  = alloc_valid && alloc_ready && !flush_s;
  assign head_ready_s  = rob_r[head_r].valid && rob_r[head_r].done;
  assign retire_fire_s = head_ready_s && !flush_s;

  assign retire_valid        = retire_fire_s;
  assign retire_archReg      = rob_r[head_r].archReg;
  assign retire_destReg_p    = rob_r[head_r].destReg_p;
  assign retire_oldDestReg_p = rob_r[head_r].oldDestReg_p;
  assign retire_data         = rob_r[head_r].data;
  assign retire_is_store     = rob_r[head_r].is_store;
  assign count               = count_r;

  // Flatten entry state for the operand lookups.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      valid_s[i] = rob_r[i].valid;
      done_s[i]  = rob_r[i].done;
      data_s[i]  = rob_r[i].data;
    end
  end

  // Entry storage and head/tail/count pointers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) rob_r[i] <= '0;
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= '0;
    end else if (flush_s) begin
      for (int i = 0; i < DEPTH; i++) begin
        rob_r[i].valid <= 1'b0;
        rob_r[i].done  <= 1'b0;
      end
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= '0;
    end else begin
      // Port 0 is applied last so it wins a same-tag collision.
      if (wb_valid2 && rob_r[wb_robNum2].valid) begin
        rob_r[wb_robNum2].done <= 1'b1;
        rob_r[wb_robNum2].data <= wb_data2;
      end
      if (wb_valid1 && rob_r[wb_robNum1].valid) begin
        rob_r[wb_robNum1].done <= 1'b1;
        rob_r[wb_robNum1].data <= wb_data1;
      end
      if (wb_valid0 && rob_r[wb_robNum0].valid) begin
        rob_r[wb_robNum0].done <= 1'b1;
        rob_r[wb_robNum0].data <= wb_data0;
      end
      if (retire_fire_s) begin
        rob_r[head_r].valid <= 1'b0;
        rob_r[head_r].done  <= 1'b0;
        head_r              <= head_r + 1'b1;
      end
      if (alloc_fire_s) begin
        rob_r[tail_r] <= '{valid: 1'b1, done: 1'b0, PC: alloc_PC,
                           archReg: alloc_archReg, destReg_p: alloc_destReg_p,
                           oldDestReg_p: alloc_oldDestReg_p,
                           is_store: alloc_is_store, data: 32'd0};
        tail_r        <= tail_r + 1'b1;
      end
      case ({alloc_fire_s, retire_fire_s})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

  rob_src_lookup #(.DEPTH(DEPTH), .TAG_W(TAG_W)) u_src1 (
    .rob_num   (src1_robNum),
    .valid_vec (valid_s),
    .done_vec  (done_s),
    .data_arr  (data_s),
    .wb_valid0 (wb_valid0), .wb_robNum0 (wb_robNum0), .wb_data0 (wb_data0),
    .wb_valid1 (wb_valid1), .wb_robNum1 (wb_robNum1), .wb_data1 (wb_data1),
    .wb_valid2 (wb_valid2), .wb_robNum2 (wb_robNum2), .wb_data2 (wb_data2),
    .ready     (src1_ready),
    .data      (src1_data)
  );

  rob_src_lookup #(.DEPTH(DEPTH), .TAG_W(TAG_W)) u_src2 (
    .rob_num   (src2_robNum),
    .valid_vec (valid_s),
    .done_vec  (done_s),
    .data_arr  (data_s),
    .wb_valid0 (wb_valid0), .wb_robNum0 (wb_robNum0), .wb_data0 (wb_data0),
    .wb_valid1 (wb_valid1), .wb_robNum1 (wb_robNum1), .wb_data1 (wb_data1),
    .wb_valid2 (wb_valid2), .wb_robNum2 (wb_robNum2), .wb_data2 (wb_data2),
    .ready     (src2_ready),
    .data      (src2_data)
  );

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed self-checking bench for reorder_buffer (flush scenario only with ROB_FLUSH_EN).
module tb_reorder_buffer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        alloc_valid, alloc_is_store;
  logic [31:0] alloc_PC;
  logic [4:0]  alloc_archReg;
  logic [5:0]  alloc_destReg_p, alloc_oldDestReg_p;
  logic        alloc_ready;
  logic [5:0]  alloc_robNum;
  logic        wb_valid0, wb_valid1, wb_valid2;
  logic [5:0]  wb_robNum0, wb_robNum1, wb_robNum2;
  logic [31:0] wb_data0, wb_data1, wb_data2;
  logic [5:0]  src1_robNum, src2_robNum;
  logic        src1_ready, src2_ready;
  logic [31:0] src1_data, src2_data;
  logic        retire_valid, retire_is_store;
  logic [4:0]  retire_archReg;
  logic [5:0]  retire_destReg_p, retire_oldDestReg_p;
  logic [31:0] retire_data;
  logic [6:0]  count;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  reorder_buffer dut (
    .clk(clk), .rst(rst),
`ifdef ROB_FLUSH_EN
    .flush(flush),
`endif
    .alloc_valid(alloc_valid), .alloc_PC(alloc_PC), .alloc_archReg(alloc_archReg),
    .alloc_destReg_p(alloc_destReg_p), .alloc_oldDestReg_p(alloc_oldDestReg_p),
    .alloc_is_store(alloc_is_store), .alloc_ready(alloc_ready), .alloc_robNum(alloc_robNum),
    .wb_valid0(wb_valid0), .wb_robNum0(wb_robNum0), .wb_data0(wb_data0),
    .wb_valid1(wb_valid1), .wb_robNum1(wb_robNum1), .wb_data1(wb_data1),
    .wb_valid2(wb_valid2), .wb_robNum2(wb_robNum2), .wb_data2(wb_data2),
    .src1_robNum(src1_robNum), .src2_robNum(src2_robNum),
    .src1_ready(src1_ready), .src2_ready(src2_ready),
    .src1_data(src1_data), .src2_data(src2_data),
    .retire_valid(retire_valid), .retire_archReg(retire_archReg),
    .retire_destReg_p(retire_destReg_p), .retire_oldDestReg_p(retire_oldDestReg_p),
    .retire_data(retire_data), .retire_is_store(retire_is_store), .count(count)
  );

  task automatic idle_inputs();
    alloc_valid = 1'b0; alloc_PC = 32'd0; alloc_archReg = 5'd0; alloc_destReg_p = 6'd0;
    alloc_oldDestReg_p = 6'd0; alloc_is_store = 1'b0; flush = 1'b0;
    wb_valid0 = 1'b0; wb_robNum0 = 6'd0; wb_data0 = 32'd0;
    wb_valid1 = 1'b0; wb_robNum1 = 6'd0; wb_data1 = 32'd0;
    wb_valid2 = 1'b0; wb_robNum2 = 6'd0; wb_data2 = 32'd0;
    src1_robNum = 6'd0; src2_robNum = 6'd0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_alloc(input int i);
    alloc_valid        = 1'b1;
    alloc_PC           = 32'h1000 + 32'(i * 4);
    alloc_archReg      = 5'(i + 1);
    alloc_destReg_p    = 6'(i + 10);
    alloc_oldDestReg_p = 6'(i + 20);
    alloc_is_store     = (i == 1);
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    next_cycle();
    total++; if (count !== 7'd0) begin bad++; $display("FAIL rst_count got=%0d exp=0", count); end
    total++; if (alloc_ready !== 1'b1) begin bad++; $display("FAIL rst_alloc_ready got=%b exp=1", alloc_ready); end
    total++; if (alloc_robNum !== 6'd0) begin bad++; $display("FAIL rst_robnum got=%0d exp=0", alloc_robNum); end
    total++; if ({retire_valid, retire_data, src1_ready} !== 34'd0) begin bad++;
      $display("FAIL rst_outputs got rv=%b rd=%h s1r=%b exp zeros", retire_valid, retire_data, src1_ready); end
    rst = 1'b0;
  endtask

  task automatic test_basic_order();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive_alloc(i); #1;
      total++; if (alloc_robNum !== 6'(i)) begin bad++; $display("FAIL basic_tag got=%0d exp=%0d", alloc_robNum, i); end
      next_cycle();
    end
    alloc_valid = 1'b0;
    wb_valid1 = 1'b1; wb_robNum1 = 6'd2; wb_data1 = 32'hC2; #1;
    total++; if (retire_valid !== 1'b0) begin bad++; $display("FAIL basic_noretire_a got=%b exp=0", retire_valid); end
    next_cycle();
    wb_robNum1 = 6'd0; wb_data1 = 32'hC0; #1;
    total++; if (retire_valid !== 1'b0) begin bad++; $display("FAIL basic_noretire_b got=%b exp=0", retire_valid); end
    next_cycle();
    wb_robNum1 = 6'd1; wb_data1 = 32'hC1; #1;
    total++; if ({retire_valid, retire_archReg, retire_destReg_p, retire_data} !== {1'b1, 5'd1, 6'd10, 32'hC0}) begin bad++;
      $display("FAIL basic_retire0 got v=%b ar=%0d pd=%0d d=%h exp v=1 ar=1 pd=10 d=c0", retire_valid, retire_archReg, retire_destReg_p, retire_data); end
    next_cycle();
    wb_valid1 = 1'b0; #1;
    total++; if ({retire_valid, retire_is_store, retire_oldDestReg_p, retire_data} !== {1'b1, 1'b1, 6'd21, 32'hC1}) begin bad++;
      $display("FAIL basic_retire1 got v=%b st=%b opd=%0d d=%h exp v=1 st=1 opd=21 d=c1", retire_valid, retire_is_store, retire_oldDestReg_p, retire_data); end
    next_cycle();
    total++; if ({retire_valid, retire_archReg, retire_data} !== {1'b1, 5'd3, 32'hC2}) begin bad++;
      $display("FAIL basic_retire2 got v=%b ar=%0d d=%h exp v=1 ar=3 d=c2", retire_valid, retire_archReg, retire_data); end
    next_cycle();
    total++; if ({retire_valid, count} !== {1'b0, 7'd0}) begin bad++; $display("FAIL basic_drained got v=%b cnt=%0d exp v=0 cnt=0", retire_valid, count); end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 64; i++) begin drive_alloc(i); next_cycle(); end
    drive_alloc(99); #1;
    total++; if ({count, alloc_ready} !== {7'd64, 1'b0}) begin bad++; $display("FAIL full_state got cnt=%0d rdy=%b exp cnt=64 rdy=0", count, alloc_ready); end
    next_cycle();
    alloc_valid = 1'b0;
    total++; if ({count, alloc_robNum} !== {7'd64, 6'd0}) begin bad++; $display("FAIL full_reject got cnt=%0d tag=%0d exp cnt=64 tag=0", count, alloc_robNum); end
    wb_valid0 = 1'b1; wb_robNum0 = 6'd0; wb_data0 = 32'h55;
    next_cycle();
    wb_valid0 = 1'b0; drive_alloc(100); #1;
    total++; if ({retire_valid, retire_data, alloc_ready} !== {1'b1, 32'h55, 1'b0}) begin bad++;
      $display("FAIL full_retire got v=%b d=%h rdy=%b exp v=1 d=55 rdy=0", retire_valid, retire_data, alloc_ready); end
    next_cycle();
    alloc_valid = 1'b0; #1;
    total++; if ({count, alloc_ready, alloc_robNum, retire_valid} !== {7'd63, 1'b1, 6'd0, 1'b0}) begin bad++;
      $display("FAIL full_after got cnt=%0d rdy=%b tag=%0d rv=%b exp cnt=63 rdy=1 tag=0 rv=0", count, alloc_ready, alloc_robNum, retire_valid); end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 70; i++) begin
      drive_alloc(i);
      wb_valid0 = (i >= 1); wb_robNum0 = 6'((i + 63) % 64); wb_data0 = 32'h100 + 32'(i - 1); #1;
      total++; if (alloc_robNum !== 6'(i % 64)) begin bad++; $display("FAIL wrap_tag i=%0d got=%0d exp=%0d", i, alloc_robNum, i % 64); end
      if (i >= 2) begin
        total++; if ({retire_valid, retire_data} !== {1'b1, 32'h100 + 32'(i - 2)}) begin bad++;
          $display("FAIL wrap_retire i=%0d got v=%b d=%h exp v=1 d=%h", i, retire_valid, retire_data, 32'h100 + 32'(i - 2)); end
      end
      next_cycle();
    end
    alloc_valid = 1'b0; wb_robNum0 = 6'd5; wb_data0 = 32'h100 + 32'd69;
    next_cycle();
    wb_valid0 = 1'b0;
    next_cycle();
    total++; if ({count, retire_valid, alloc_robNum} !== {7'd0, 1'b0, 6'd6}) begin bad++;
      $display("FAIL wrap_drain got cnt=%0d rv=%b tag=%0d exp cnt=0 rv=0 tag=6", count, retire_valid, alloc_robNum); end
  endtask

  task automatic test_bypass();
    do_reset();
    for (int i = 0; i < 6; i++) begin drive_alloc(i); next_cycle(); end
    alloc_valid = 1'b0;
    src1_robNum = 6'd5; src2_robNum = 6'd4;
    wb_valid0 = 1'b1; wb_robNum0 = 6'd5; wb_data0 = 32'hAA;
    wb_valid2 = 1'b1; wb_robNum2 = 6'd5; wb_data2 = 32'hBB; #1;
    total++; if ({src1_ready, src1_data} !== {1'b1, 32'hAA}) begin bad++; $display("FAIL byp_src1 got r=%b d=%h exp r=1 d=aa", src1_ready, src1_data); end
    total++; if ({src2_ready, src2_data} !== {1'b0, 32'd0}) begin bad++; $display("FAIL byp_src2 got r=%b d=%h exp r=0 d=0", src2_ready, src2_data); end
    next_cycle();
    wb_valid0 = 1'b0; wb_valid2 = 1'b0;
    wb_valid1 = 1'b1; wb_robNum1 = 6'd9; wb_data1 = 32'h77; #1;
    total++; if ({src1_ready, src1_data, retire_valid} !== {1'b1, 32'hAA, 1'b0}) begin bad++;
      $display("FAIL byp_stored got r=%b d=%h rv=%b exp r=1 d=aa rv=0", src1_ready, src1_data, retire_valid); end
    next_cycle();
    wb_valid1 = 1'b0; src2_robNum = 6'd9; #1;
    total++; if ({src2_ready, src2_data} !== {1'b0, 32'd0}) begin bad++; $display("FAIL byp_invalid_wb got r=%b d=%h exp r=0 d=0", src2_ready, src2_data); end
  endtask

  task automatic test_midrun_reset();
    do_reset();
    for (int i = 0; i < 10; i++) begin drive_alloc(i); next_cycle(); end
    alloc_valid = 1'b0; wb_valid0 = 1'b1; wb_robNum0 = 6'd0; wb_data0 = 32'h11;
    next_cycle();
    wb_valid0 = 1'b0; #1;
    total++; if ({count, retire_valid} !== {7'd10, 1'b1}) begin bad++; $display("FAIL mid_pre got cnt=%0d rv=%b exp cnt=10 rv=1", count, retire_valid); end
    rst = 1'b1; #1;
    total++; if ({count, retire_valid, alloc_robNum, alloc_ready, retire_data} !== {7'd0, 1'b0, 6'd0, 1'b1, 32'd0}) begin bad++;
      $display("FAIL mid_rst got cnt=%0d rv=%b tag=%0d rdy=%b d=%h exp 0 0 0 1 0", count, retire_valid, alloc_robNum, alloc_ready, retire_data); end
    next_cycle();
    rst = 1'b0; src1_robNum = 6'd0; #1;
    total++; if ({retire_valid, src1_ready} !== 2'b00) begin bad++; $display("FAIL mid_after got rv=%b s1r=%b exp 0 0", retire_valid, src1_ready); end
    next_cycle();
    total++; if (count !== 7'd0) begin bad++; $display("FAIL mid_count got=%0d exp=0", count); end
  endtask

`ifdef ROB_FLUSH_EN
  task automatic test_flush();
    do_reset();
    for (int i = 0; i < 3; i++) begin drive_alloc(i); next_cycle(); end
    drive_alloc(3); flush = 1'b1;
    next_cycle();
    flush = 1'b0; alloc_valid = 1'b0; #1;
    total++; if ({count, alloc_robNum, retire_valid} !== {7'd0, 6'd0, 1'b0}) begin bad++;
      $display("FAIL flush_state got cnt=%0d tag=%0d rv=%b exp 0 0 0", count, alloc_robNum, retire_valid); end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_basic_order();
    test_full();
    test_wrap();
    test_bypass();
    test_midrun_reset();
`ifdef ROB_FLUSH_EN
    test_flush();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
